// File: rtl/servo_spi_cmd_pkg.sv
// servo_spi_cmd_pkg
//   Constants, state encoding and a small helper used by the servo SPI
//   command slave. Holds the values that a separate defines header would
//   otherwise carry: opcode, frame length, FSM encodings and the servo
//   period in microseconds.
//   Optional feature macro used by this slice: SERVO_SPI_MISO_EN.
package servo_spi_cmd_pkg;

    localparam logic [3:0] OPC_WRITE     = 4'hA;
    localparam int         FRAME_LEN     = 24;
    localparam int         US_PER_PERIOD = 20000;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        CHECK     = 2'd3
    } state_t;

    // Unsigned 16-bit clamp of a pulse width against its upper limit.
    function automatic logic [15:0] clamp_us(input logic [15:0] value,
                                             input logic [15:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/servo_spi_cmd_if.sv
// servo_spi_cmd_if
//   SPI pin bundle between the host MCU (master) and the servo command
//   slave. All pins are asynchronous to the slave's system clock.
//   Signals: spi_sclk, spi_cs_n (active-low), spi_mosi (MSB first), spi_miso.
//   Optional feature macro affecting spi_miso content: SERVO_SPI_MISO_EN.
interface servo_spi_cmd_if;

    logic spi_sclk;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;

    modport master (output spi_sclk, output spi_cs_n, output spi_mosi, input spi_miso);
    modport slave  (input spi_sclk, input spi_cs_n, input spi_mosi, output spi_miso);

endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
//   Two-flop synchronizer for one asynchronous pin, plus a registered copy
//   of the synchronized value for edge detection.
//   Ports: clk, rst (async active-low), din (async pin),
//          sync (synchronized level), rise / fall (one-cycle edge pulses).
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    // Every stage resets low. For chip select this means that a reset taken
    // while cs_n is held low leaves the synchronized level low, so the
    // controller stays parked until the host really deselects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/servo_spi_cmd.sv
// servo_spi_cmd
//   SPI mode-0 slave receiving 24-bit servo command frames
//   {opcode[3:0], channel[3:0], width_us[15:0]}, MSB first. A valid WRITE
//   frame produces a one-cycle one-hot load strobe on its channel with the
//   clamped pulse width on data; a rejected frame produces a one-cycle
//   frame_err pulse.
//   Ports: clk, rst (async active-low), spi (SPI pins, slave modport),
//          load[NUM_CH], data[16], frame_err,
//          ok_cnt / err_cnt (4-bit wrapping debug counters).
//   Optional feature macro: SERVO_SPI_MISO_EN -- when defined, spi_miso
//   shifts out {ok_cnt, err_cnt} during the first 8 bits of each frame;
//   otherwise spi_miso is tied low.
module servo_spi_cmd
    import servo_spi_cmd_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int MAX_US     = 2500,
    parameter int FRAME_BITS = FRAME_LEN
) (
    input  logic                clk,
    input  logic                rst,
    servo_spi_cmd_if.slave      spi,
    output logic [NUM_CH-1:0]   load,
    output logic [15:0]         data,
    output logic                frame_err,
    output logic [3:0]          ok_cnt,
    output logic [3:0]          err_cnt
);

    localparam logic [4:0]  FULL_CNT = 5'(FRAME_BITS);
    localparam logic [4:0]  OVER_CNT = 5'(FRAME_BITS + 1);
    localparam logic [15:0] MAX_W    = 16'(MAX_US);
    localparam logic [4:0]  CH_LIMIT = 5'(NUM_CH);

    state_t state;
    state_t next_state;

    logic sclk_sync, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_meta, mosi_sync;

    logic [FRAME_BITS-1:0] shift_reg;
    logic [4:0]            bit_cnt;
    logic                  overrun;
    logic                  frame_ok;
    logic [3:0]            opcode;
    logic [3:0]            channel;
    logic [NUM_CH-1:0]     one_hot;
    logic                  unused_sync;

    spi_sync_edge u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (spi.spi_sclk),
        .sync (sclk_sync),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (spi.spi_cs_n),
        .sync (cs_sync),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // MOSI goes through the same two-flop depth as sclk, so the synced data
    // bit lines up with the synced rising edge that samples it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            mosi_meta <= spi.spi_mosi;
            mosi_sync <= mosi_meta;
        end
    end

    assign opcode  = shift_reg[FRAME_BITS-1 -: 4];
    assign channel = shift_reg[FRAME_BITS-5 -: 4];

    always_comb begin
        frame_ok = (bit_cnt == FULL_CNT) && !overrun && (opcode == OPC_WRITE)
                   && ({1'b0, channel} < CH_LIMIT);
    end

    always_comb begin
        one_hot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (channel == 4'(i)) begin
                one_hot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WAIT_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // WAIT_IDLE only releases once chip select is seen high, so a frame cut
    // by reset is never mistaken for the start of a new one.
    always_comb begin
        next_state = state;
        unique case (state)
            WAIT_IDLE: if (cs_sync) next_state = IDLE;
            IDLE:      if (cs_fall) next_state = SHIFT;
            SHIFT:     if (cs_rise) next_state = CHECK;
            CHECK:     next_state = IDLE;
            default:   next_state = WAIT_IDLE;
        endcase
    end

    // Shift register and bit counter. The counter saturates one past a full
    // frame; reaching that value marks the frame as overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            overrun   <= 1'b0;
        end else if (state == IDLE && cs_fall) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            overrun   <= 1'b0;
        end else if (state == SHIFT && sclk_rise) begin
            if (bit_cnt < FULL_CNT) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_sync};
                bit_cnt   <= bit_cnt + 5'd1;
            end else if (bit_cnt == FULL_CNT) begin
                bit_cnt <= OVER_CNT;
                overrun <= 1'b1;
            end
        end
    end

    // Result outputs: strobes default low every cycle and are raised only in
    // the single CHECK cycle; data holds between accepted frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load      <= '0;
            data      <= '0;
            frame_err <= 1'b0;
            ok_cnt    <= '0;
            err_cnt   <= '0;
        end else begin
            load      <= '0;
            frame_err <= 1'b0;
            if (state == CHECK) begin
                if (frame_ok) begin
                    data   <= clamp_us(shift_reg[15:0], MAX_W);
                    load   <= one_hot;
                    ok_cnt <= ok_cnt + 4'd1;
                end else begin
                    frame_err <= 1'b1;
                    err_cnt   <= err_cnt + 4'd1;
                end
            end
        end
    end

`ifdef SERVO_SPI_MISO_EN
    logic [7:0] status_sh;

    // Status byte is snapshotted at frame start so the MSB is on the pin
    // before the first sclk rise; each synced falling edge advances one bit
    // and zeros fill in behind, covering the 16 payload bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_sh <= '0;
        end else if (state == IDLE && cs_fall) begin
            status_sh <= {ok_cnt, err_cnt};
        end else if (state == SHIFT) begin
            if (sclk_fall) begin
                status_sh <= {status_sh[6:0], 1'b0};
            end
        end else begin
            status_sh <= '0;
        end
    end

    assign spi.spi_miso = (state == SHIFT) & status_sh[7];
    assign unused_sync  = sclk_sync;
`else
    assign spi.spi_miso = 1'b0;
    assign unused_sync  = sclk_sync ^ sclk_fall;
`endif

endmodule

// File: tb/tb_servo_spi_cmd.sv
// tb_servo_spi_cmd
//   Self-checking bench for servo_spi_cmd. Drives SPI frames through the
//   interface at sclk = clk/10 and compares strobes, data, counters and
//   MISO content against a frame-level reference model.
//   Optional feature macro: SERVO_SPI_MISO_EN (selects expected MISO data).
module tb_servo_spi_cmd;

    localparam int NUM_CH = 4;
    localparam int MAX_US = 2500;

    logic              clk;
    logic              rst;
    logic [NUM_CH-1:0] load;
    logic [15:0]       data;
    logic              frame_err;
    logic [3:0]        ok_cnt;
    logic [3:0]        err_cnt;

    servo_spi_cmd_if bus ();

    servo_spi_cmd #(
        .NUM_CH (NUM_CH),
        .MAX_US (MAX_US)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .spi       (bus),
        .load      (load),
        .data      (data),
        .frame_err (frame_err),
        .ok_cnt    (ok_cnt),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: last accepted width and accept/reject totals.
    int m_data = 0;
    int m_ok   = 0;
    int m_err  = 0;

    logic [31:0] obs_miso;
    int          miso_n;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic csLow();
        bus.spi_cs_n = 1'b0;
        tick(8);
    endtask

    // Sends the low n bits of word MSB first, recording MISO just before
    // each rising sclk edge.
    task automatic shiftBits(input logic [31:0] word, input int n);
        obs_miso = '0;
        miso_n   = n;
        for (int i = n - 1; i >= 0; i--) begin
            bus.spi_mosi = word[i];
            tick(5);
            obs_miso = {obs_miso[30:0], bus.spi_miso};
            bus.spi_sclk = 1'b1;
            tick(5);
            bus.spi_sclk = 1'b0;
        end
        tick(5);
    endtask

    // Raises cs_n and watches six cycles; the strobe must land on cycle 4.
    task automatic csHighAndWatch(input string tag, input logic [31:0] exp_load,
                                  input logic exp_err);
        logic [31:0] load4;
        logic        err4;
        logic        stray;
        load4 = '0;
        err4  = 1'b0;
        stray = 1'b0;
        bus.spi_cs_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            if (k == 4) begin
                load4 = 32'(load);
                err4  = frame_err;
            end else begin
                stray = stray | (|load) | frame_err;
            end
        end
        checkOutput({tag, ".load"}, load4, exp_load);
        checkOutput({tag, ".frame_err"}, 32'(err4), 32'(exp_err));
        checkOutput({tag, ".stray_pulse"}, 32'(stray), 32'd0);
        tick(10);
    endtask

    // One complete frame: model prediction, stimulus and all checks.
    task automatic applyStimulus(input string tag, input logic [23:0] frame, input int n);
        logic [31:0] word;
        logic [31:0] exp_load;
        logic [31:0] exp_miso;
        logic [7:0]  status;
        int          ch;
        int          width;
        bit          valid;

        status = {4'(m_ok), 4'(m_err)};
        ch     = int'(frame[19:16]);
        width  = int'(frame[15:0]);
        valid  = (n == 24) && (frame[23:20] == 4'hA) && (ch < NUM_CH);

        if (n == 23)      word = 32'(frame >> 1);
        else if (n == 25) word = {7'd0, frame, 1'b1};
        else              word = {8'd0, frame};

        exp_load = '0;
        if (valid) begin
            exp_load = 32'd1 << ch;
            m_data   = (width > MAX_US) ? MAX_US : width;
            m_ok     = (m_ok + 1) % 16;
        end else begin
            m_err = (m_err + 1) % 16;
        end

        exp_miso = '0;
`ifdef SERVO_SPI_MISO_EN
        for (int i = 0; i < n; i++) begin
            exp_miso = {exp_miso[30:0], (i < 8) ? status[7 - i] : 1'b0};
        end
`endif

        csLow();
        shiftBits(word, n);
        checkOutput({tag, ".miso"}, obs_miso, exp_miso);
        csHighAndWatch(tag, exp_load, !valid);
        checkOutput({tag, ".data"}, 32'(data), 32'(m_data));
        checkOutput({tag, ".ok_cnt"}, 32'(ok_cnt), 32'(m_ok));
        checkOutput({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_err));
    endtask

    initial begin
        logic [3:0]  r_op;
        logic [3:0]  r_ch;
        logic [15:0] r_val;
        int          r_sel;

        bus.spi_sclk = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        rst = 1'b0;
        tick(5);

        checkOutput("reset.load", 32'(load), 32'd0);
        checkOutput("reset.data", 32'(data), 32'd0);
        checkOutput("reset.frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset.miso", 32'(bus.spi_miso), 32'd0);
        checkOutput("reset.counters", {24'd0, ok_cnt, err_cnt}, 32'd0);

        rst = 1'b1;
        tick(10);

        applyStimulus("valid_ch1", 24'hA105DC, 24);
        applyStimulus("clamp_ch0", 24'hA0FFFF, 24);
        applyStimulus("bad_channel", 24'hA403E8, 24);
        applyStimulus("bad_opcode", 24'h5203E8, 24);
        applyStimulus("short_frame", 24'hA10100, 23);
        applyStimulus("long_frame", 24'hA10100, 25);

        // Reset in the middle of a frame, then finish the frame: nothing
        // may be accepted or rejected.
        csLow();
        shiftBits(32'h00000A2A, 12);
        rst = 1'b0;
        #1;
        checkOutput("midreset.data", 32'(data), 32'd0);
        checkOutput("midreset.counters", {24'd0, ok_cnt, err_cnt}, 32'd0);
        tick(3);
        rst = 1'b1;
        m_data = 0;
        m_ok   = 0;
        m_err  = 0;
        shiftBits(32'h00000555, 12);
        checkOutput("midreset.miso", obs_miso, 32'd0);
        csHighAndWatch("midreset", 32'd0, 1'b0);
        checkOutput("midreset.err_cnt", 32'(err_cnt), 32'd0);

        applyStimulus("zero_ch2", 24'hA20000, 24);
        applyStimulus("valid_ch3", 24'hA307D0, 24);
        applyStimulus("valid_ch0", 24'hA001F4, 24);
        applyStimulus("bad_opcode2", 24'h7100AA, 24);
        applyStimulus("status_frame", 24'hA00100, 24);

        for (int f = 0; f < 20; f++) begin
            r_op  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hA;
            r_ch  = 4'($urandom_range(0, 5));
            r_val = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 3000));
            r_sel = $urandom_range(0, 5);
            applyStimulus($sformatf("rand%0d", f), {r_op, r_ch, r_val},
                          (r_sel == 0) ? 23 : ((r_sel == 1) ? 25 : 24));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
